// File: rtl/bmp_stream_writer.sv
// rtl/bmp_stream_writer.sv - 24-bit BMP file byte stream generator from a pixel beat stream
// Emits the 54-byte header, then each row as B,G,R bytes followed by zero padding to 4 bytes.
module bmp_stream_writer #(
    parameter int IMAGE_WIDTH     = 768,
    parameter int IMAGE_HEIGHT    = 512,
    parameter int PIXELS_PER_BEAT = 2,
    parameter bit GRAY_MODE       = 1'b0,
    parameter bit TOP_DOWN        = 1'b0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         pix_Valid,
    output logic                         pix_Ready,
    input  logic [24*PIXELS_PER_BEAT-1:0] pix_Data,
    output logic                         byte_Valid,
    input  logic                         byte_Ready,
    output logic [7:0]                   byte_Data,
    output logic                         byte_Last,
    output logic                         busy,
    output logic                         sig_Write_Done
);
    localparam int ROW_BYTES = ((IMAGE_WIDTH * 3 + 3) / 4) * 4;
    localparam int PAD_BYTES = ROW_BYTES - IMAGE_WIDTH * 3;
    localparam int IMG_SIZE  = ROW_BYTES * IMAGE_HEIGHT;
    localparam int FILE_SIZE = 54 + IMG_SIZE;
    localparam int BEATS     = IMAGE_WIDTH / PIXELS_PER_BEAT;
    localparam int BW        = 24 * PIXELS_PER_BEAT;
    localparam int PW        = (PIXELS_PER_BEAT > 1) ? $clog2(PIXELS_PER_BEAT) : 1;
    localparam int CW        = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int RW        = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
    localparam int OW        = $clog2(BW);

    localparam logic [31:0] FILE_SIZE_F = 32'(FILE_SIZE);
    localparam logic [31:0] IMG_SIZE_F  = 32'(IMG_SIZE);
    localparam logic [31:0] WIDTH_F     = 32'(IMAGE_WIDTH);
    localparam logic [31:0] HEIGHT_F    = TOP_DOWN ? 32'(-IMAGE_HEIGHT) : 32'(IMAGE_HEIGHT);

    typedef enum logic [2:0] {IDLE, HEADER, PIXEL, PAD, DONE} state_t;

    state_t          state;
    logic [5:0]      hdr_idx;
    logic [BW-1:0]   beat;
    logic            full;
    logic [PW-1:0]   pix_sel;
    logic [1:0]      comp;
    logic [CW-1:0]   col;
    logic [RW-1:0]   row;
    logic [1:0]      pad_cnt;

    logic            last_in_beat;
    logic            last_col;
    logic            last_row;
    logic            last_pad;
    logic [1:0]      comp_eff;
    logic [OW-1:0]   bit_off;

    function automatic logic [7:0] le_byte(input logic [31:0] v, input logic [1:0] n);
        logic [7:0] b;
        case (n)
            2'd0:    b = v[7:0];
            2'd1:    b = v[15:8];
            2'd2:    b = v[23:16];
            default: b = v[31:24];
        endcase
        return b;
    endfunction

    // Every multi-byte field starts at an offset of 2 mod 4, so idx-2 gives the byte lane.
    function automatic logic [7:0] header_byte(input logic [5:0] idx);
        logic [7:0] b;
        logic [1:0] n;
        n = idx[1:0] - 2'd2;
        b = 8'h00;
        case (idx)
            6'd0:                      b = 8'h42;
            6'd1:                      b = 8'h4D;
            6'd2, 6'd3, 6'd4, 6'd5:    b = le_byte(FILE_SIZE_F, n);
            6'd10:                     b = 8'd54;
            6'd14:                     b = 8'd40;
            6'd18, 6'd19, 6'd20, 6'd21: b = le_byte(WIDTH_F, n);
            6'd22, 6'd23, 6'd24, 6'd25: b = le_byte(HEIGHT_F, n);
            6'd26:                     b = 8'd1;
            6'd28:                     b = 8'd24;
            6'd34, 6'd35, 6'd36, 6'd37: b = le_byte(IMG_SIZE_F, n);
            default:                   b = 8'h00;
        endcase
        return b;
    endfunction

    always_comb begin
        last_in_beat = (comp == 2'd2) && (pix_sel == PW'(PIXELS_PER_BEAT - 1));
        last_col     = (col == CW'(BEATS - 1));
        last_row     = (row == RW'(IMAGE_HEIGHT - 1));
        last_pad     = (pad_cnt == 2'(PAD_BYTES - 1));
        comp_eff     = GRAY_MODE ? 2'd2 : comp;
        bit_off      = OW'(pix_sel) * OW'(24) + OW'(comp_eff) * OW'(8);

        pix_Ready  = (state == PIXEL) && !full;
        byte_Valid = (state == HEADER) || ((state == PIXEL) && full) || (state == PAD);
        byte_Data  = 8'h00;
        byte_Last  = 1'b0;
        case (state)
            HEADER: byte_Data = header_byte(hdr_idx);
            PIXEL: begin
                if (full) begin
                    byte_Data = beat[bit_off +: 8];
                    byte_Last = last_in_beat && last_col && last_row && (PAD_BYTES == 0);
                end
            end
            PAD:     byte_Last = last_pad && last_row;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            busy           <= 1'b0;
            sig_Write_Done <= 1'b0;
            hdr_idx        <= '0;
            beat           <= '0;
            full           <= 1'b0;
            pix_sel        <= '0;
            comp           <= '0;
            col            <= '0;
            row            <= '0;
            pad_cnt        <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state          <= HEADER;
                        busy           <= 1'b1;
                        sig_Write_Done <= 1'b0;
                        hdr_idx        <= '0;
                        full           <= 1'b0;
                        pix_sel        <= '0;
                        comp           <= '0;
                        col            <= '0;
                        row            <= '0;
                        pad_cnt        <= '0;
                    end
                end
                HEADER: begin
                    if (byte_Ready) begin
                        if (hdr_idx == 6'd53) begin
                            state   <= PIXEL;
                            hdr_idx <= '0;
                        end else begin
                            hdr_idx <= hdr_idx + 6'd1;
                        end
                    end
                end
                PIXEL: begin
                    if (!full) begin
                        if (pix_Valid) begin
                            beat <= pix_Data;
                            full <= 1'b1;
                        end
                    end else if (byte_Ready) begin
                        if (comp != 2'd2) begin
                            comp <= comp + 2'd1;
                        end else begin
                            comp <= 2'd0;
                            if (!last_in_beat) begin
                                pix_sel <= pix_sel + PW'(1);
                            end else begin
                                pix_sel <= '0;
                                full    <= 1'b0;
                                if (!last_col) begin
                                    col <= col + CW'(1);
                                end else begin
                                    col <= '0;
                                    if (PAD_BYTES > 0) begin
                                        state <= PAD;
                                    end else if (last_row) begin
                                        state          <= DONE;
                                        busy           <= 1'b0;
                                        sig_Write_Done <= 1'b1;
                                    end else begin
                                        row <= row + RW'(1);
                                    end
                                end
                            end
                        end
                    end
                end
                PAD: begin
                    if (byte_Ready) begin
                        if (!last_pad) begin
                            pad_cnt <= pad_cnt + 2'd1;
                        end else begin
                            pad_cnt <= '0;
                            if (last_row) begin
                                state          <= DONE;
                                busy           <= 1'b0;
                                sig_Write_Done <= 1'b1;
                            end else begin
                                state <= PIXEL;
                                row   <= row + RW'(1);
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bmp_stream_writer.sv
// tb/tb_bmp_stream_writer.sv - randomized bench for bmp_stream_writer against a BMP file layout model
module tb_bmp_stream_writer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [1:0]  sel;
    logic        g_start, g_pv, g_br;
    logic [95:0] g_pd;
    logic        g_pr, g_bv, g_bl, g_busy, g_done;
    logic [7:0]  g_bd;
    logic [3:0]  pr, bv, bl, bz, dn;
    logic [3:0][7:0] bd;

    int          n_checks, n_errors;
    int          m_w, m_h, m_gray, m_td;
    logic [23:0] pix_q[$];
    logic [7:0]  cap[$];
    bit          stop;

    assign g_pr   = pr[sel];
    assign g_bv   = bv[sel];
    assign g_bl   = bl[sel];
    assign g_busy = bz[sel];
    assign g_done = dn[sel];
    assign g_bd   = bd[sel];

    bmp_stream_writer u0 (
        .clk(clk), .reset(rst), .start(g_start && sel == 2'd0), .pix_Valid(g_pv && sel == 2'd0),
        .pix_Ready(pr[0]), .pix_Data(g_pd[47:0]), .byte_Valid(bv[0]), .byte_Ready(g_br && sel == 2'd0),
        .byte_Data(bd[0]), .byte_Last(bl[0]), .busy(bz[0]), .sig_Write_Done(dn[0]));

    bmp_stream_writer #(.IMAGE_WIDTH(5), .IMAGE_HEIGHT(2), .PIXELS_PER_BEAT(1)) u1 (
        .clk(clk), .reset(rst), .start(g_start && sel == 2'd1), .pix_Valid(g_pv && sel == 2'd1),
        .pix_Ready(pr[1]), .pix_Data(g_pd[23:0]), .byte_Valid(bv[1]), .byte_Ready(g_br && sel == 2'd1),
        .byte_Data(bd[1]), .byte_Last(bl[1]), .busy(bz[1]), .sig_Write_Done(dn[1]));

    bmp_stream_writer #(.IMAGE_WIDTH(8), .IMAGE_HEIGHT(4), .PIXELS_PER_BEAT(4)) u2 (
        .clk(clk), .reset(rst), .start(g_start && sel == 2'd2), .pix_Valid(g_pv && sel == 2'd2),
        .pix_Ready(pr[2]), .pix_Data(g_pd[95:0]), .byte_Valid(bv[2]), .byte_Ready(g_br && sel == 2'd2),
        .byte_Data(bd[2]), .byte_Last(bl[2]), .busy(bz[2]), .sig_Write_Done(dn[2]));

    bmp_stream_writer #(.IMAGE_WIDTH(3), .IMAGE_HEIGHT(512), .PIXELS_PER_BEAT(1),
                        .GRAY_MODE(1'b1), .TOP_DOWN(1'b1)) u3 (
        .clk(clk), .reset(rst), .start(g_start && sel == 2'd3), .pix_Valid(g_pv && sel == 2'd3),
        .pix_Ready(pr[3]), .pix_Data(g_pd[23:0]), .byte_Valid(bv[3]), .byte_Ready(g_br && sel == 2'd3),
        .byte_Data(bd[3]), .byte_Last(bl[3]), .busy(bz[3]), .sig_Write_Done(dn[3]));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Byte k of the expected file: header fields, then row-major pixels, then row padding.
    function automatic logic [7:0] exp_byte(input int k);
        logic [7:0]  hb[54];
        logic [31:0] fs, img, wf, hf;
        logic [23:0] px;
        int rb, off, r, c, idx;
        rb = ((m_w * 3 + 3) / 4) * 4;
        if (k < 54) begin
            foreach (hb[i]) hb[i] = 8'h00;
            img = 32'(rb * m_h);
            fs  = 32'd54 + img;
            wf  = 32'(m_w);
            hf  = (m_td != 0) ? 32'(-m_h) : 32'(m_h);
            hb[0] = 8'h42; hb[1] = 8'h4D; hb[10] = 8'd54; hb[14] = 8'd40;
            hb[26] = 8'd1; hb[28] = 8'd24;
            for (int i = 0; i < 4; i++) begin
                hb[2 + i]  = fs[8*i +: 8];
                hb[18 + i] = wf[8*i +: 8];
                hb[22 + i] = hf[8*i +: 8];
                hb[34 + i] = img[8*i +: 8];
            end
            return hb[k];
        end
        off = k - 54;
        r   = off / rb;
        c   = off % rb;
        if (c >= m_w * 3) return 8'h00;
        idx = r * m_w + c / 3;
        if (idx >= pix_q.size()) return 8'h00;
        px = pix_q[idx];
        if (m_gray != 0) return px[23:16];
        case (c % 3)
            0:       return px[7:0];
            1:       return px[15:8];
            default: return px[23:16];
        endcase
    endfunction

    task automatic run_frame(input logic [1:0] id, input int w, input int h, input int ppb,
                             input int gray, input int td, input int stall, input int limit,
                             input int cpix);
        int rb, total, n, nbeats, budget;
        sel = id; m_w = w; m_h = h; m_gray = gray; m_td = td;
        rb     = ((w * 3 + 3) / 4) * 4;
        total  = 54 + rb * h;
        n      = (limit > 0) ? limit : total;
        nbeats = (w * h) / ppb;
        budget = 8 * n + 200;
        pix_q.delete();
        cap.delete();
        stop = 1'b0;
        @(posedge clk); #1 g_start = 1'b1;
        @(posedge clk); #1 g_start = 1'b0;
        fork
            begin : drv
                int j;
                bit have, acc;
                logic [23:0] px;
                j = 0; have = 1'b0;
                while (j < nbeats && !stop) begin
                    if (!have) begin
                        for (int p = 0; p < ppb; p++) begin
                            if (cpix != 0) px = 24'h102030;
                            else if (gray != 0 && pix_q.size() == 0) px = 24'hFF0012;
                            else px = 24'($urandom);
                            pix_q.push_back(px);
                            g_pd[24*p +: 24] = px;
                        end
                        have = 1'b1;
                    end
                    g_pv = (stall == 0) || ($urandom_range(0, 3) != 0);
                    @(negedge clk);
                    acc = g_pv && g_pr;
                    @(posedge clk); #1;
                    if (acc) begin
                        have = 1'b0;
                        j++;
                    end
                end
                g_pv = 1'b0;
            end
            begin : snk
                int got, cyc;
                bit prev_stall;
                logic [9:0] prev;
                got = 0; cyc = 0; prev_stall = 1'b0; prev = '0;
                while (got < n && cyc < budget) begin
                    g_br = (stall == 0) || ($urandom_range(0, 2) != 0);
                    @(negedge clk);
                    cyc++;
                    if (prev_stall) check("hold_during_stall", {g_bv, g_bd, g_bl}, prev);
                    if (g_bv && g_br) begin
                        check("byte_data", g_bd, exp_byte(got));
                        check("byte_last", g_bl, (got == total - 1));
                        cap.push_back(g_bd);
                        got++;
                    end
                    prev_stall = g_bv && !g_br;
                    prev = {g_bv, g_bd, g_bl};
                    @(posedge clk); #1;
                end
                g_br = 1'b0;
                stop = 1'b1;
                if (got < n) check("byte_timeout", got, n);
            end
        join
        if (limit == 0) begin
            repeat (2) @(posedge clk);
            #1;
            check("done_state", {g_done, g_busy, g_bv}, 3'b100);
            check("frame_len", cap.size(), total);
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        n_checks = 0; n_errors = 0;
        g_start = 1'b0; g_pv = 1'b0; g_br = 1'b0; g_pd = '0; sel = 2'd0; stop = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {pr, bv, bl, bz, dn, bd}, 64'h0);
        rst = 1'b0;

        run_frame(2'd0, 768, 512, 2, 0, 0, 0, 54 + 60, 1);
        check("dflt_file_size", {cap[5], cap[4], cap[3], cap[2]}, 32'h00120036);
        check("dflt_dims", {cap[18], cap[19], cap[20], cap[21], cap[22], cap[23], cap[24], cap[25]},
              64'h0003000000020000);
        check("dflt_bpp", cap[28], 8'd24);
        check("dflt_pixel", {cap[54], cap[55], cap[56]}, 24'h302010);
        check("busy_mid_frame", g_busy, 1'b1);

        @(negedge clk);
        rst = 1'b1;
        #1;
        check("reset_mid_pixel", {g_pr, g_bv, g_bd, g_bl, g_busy, g_done}, 13'h0);
        @(posedge clk); #1 rst = 1'b0;
        run_frame(2'd0, 768, 512, 2, 0, 0, 0, 54 + 30, 1);
        check("restart_magic", {cap[0], cap[1]}, 16'h424D);

        run_frame(2'd1, 5, 2, 1, 0, 0, 0, 0, 0);
        check("small_file_size", {cap[5], cap[4], cap[3], cap[2]}, 32'h00000056);
        check("small_pad", cap[54 + 15], 8'h00);

        run_frame(2'd2, 8, 4, 4, 0, 0, 0, 0, 0);
        run_frame(2'd2, 8, 4, 4, 0, 0, 1, 0, 0);

        run_frame(2'd3, 3, 512, 1, 1, 1, 1, 0, 0);
        check("topdown_height", {cap[22], cap[23], cap[24], cap[25]}, 32'h00FEFFFF);
        check("gray_pixel", {cap[54], cap[55], cap[56]}, 24'hFFFFFF);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
